// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, quotient/remainder held until the next accepted start.
// Optional two's-complement mode is enabled with `define SEQ_DIVIDER_SIGNED_EN.
module seq_divider #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state,  w_state_nxt;
  logic [N-1:0]  r_rem,    w_rem_nxt;
  logic [N-1:0]  r_quo,    w_quo_nxt;
  logic [N-1:0]  r_div,    w_div_nxt;
  logic [CW-1:0] r_cnt,    w_cnt_nxt;
  logic          r_busy,   w_busy_nxt;
  logic          r_done,   w_done_nxt;
  logic [N-1:0]  r_q_out,  w_q_out_nxt;
  logic [N-1:0]  r_r_out,  w_r_out_nxt;
  logic          r_zero,   w_zero_nxt;

  logic [N:0]    w_shift;
  logic          w_ge;
  logic [N-1:0]  w_sub;
  logic [N-1:0]  w_rem_it;
  logic [N-1:0]  w_quo_it;
  logic [N-1:0]  w_a_mag;
  logic [N-1:0]  w_b_mag;
  logic [N-1:0]  w_q_res;
  logic [N-1:0]  w_r_res;

  // One restoring step; the partial remainder never exceeds the divisor, so N bits hold it.
  assign w_shift  = {r_rem, r_quo[N-1]};
  assign w_ge     = (w_shift >= {1'b0, r_div});
  assign w_sub    = w_shift[N-1:0] - r_div;
  assign w_rem_it = w_ge ? w_sub : w_shift[N-1:0];
  assign w_quo_it = {r_quo[N-2:0], w_ge};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic r_neg_q, w_neg_q_nxt;
  logic r_neg_r, w_neg_r_nxt;

  // The most negative value maps to itself, which is its correct unsigned magnitude.
  assign w_a_mag = a[N-1] ? -a : a;
  assign w_b_mag = b[N-1] ? -b : b;
  assign w_q_res = r_neg_q ? -w_quo_it : w_quo_it;
  assign w_r_res = r_neg_r ? -w_rem_it : w_rem_it;
`else
  assign w_a_mag = a;
  assign w_b_mag = b;
  assign w_q_res = w_quo_it;
  assign w_r_res = w_rem_it;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_quo_nxt   = r_quo;
    w_div_nxt   = r_div;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_q_out_nxt = r_q_out;
    w_r_out_nxt = r_r_out;
    w_zero_nxt  = r_zero;
`ifdef SEQ_DIVIDER_SIGNED_EN
    w_neg_q_nxt = r_neg_q;
    w_neg_r_nxt = r_neg_r;
`endif
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          if (b != '0) begin
            w_div_nxt   = w_b_mag;
            w_quo_nxt   = w_a_mag;
            w_rem_nxt   = '0;
            w_cnt_nxt   = '0;
            w_zero_nxt  = 1'b0;
            w_busy_nxt  = 1'b1;
            w_state_nxt = CALC;
`ifdef SEQ_DIVIDER_SIGNED_EN
            w_neg_q_nxt = a[N-1] ^ b[N-1];
            w_neg_r_nxt = a[N-1];
`endif
          end else begin
            w_zero_nxt  = 1'b1;
            w_q_out_nxt = '0;
            w_r_out_nxt = a;
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CALC: begin
        w_rem_nxt = w_rem_it;
        w_quo_nxt = w_quo_it;
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == LAST_CNT) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_q_out_nxt = w_q_res;
          w_r_out_nxt = w_r_res;
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = CALC;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_zero  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_quo   <= w_quo_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_q_out <= w_q_out_nxt;
      r_r_out <= w_r_out_nxt;
      r_zero  <= w_zero_nxt;
`ifdef SEQ_DIVIDER_SIGNED_EN
      r_neg_q <= w_neg_q_nxt;
      r_neg_r <= w_neg_r_nxt;
`endif
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_q_out;
  assign remainder = r_r_out;
  assign zero      = r_zero;

endmodule
